ram_loader: RTL

- Bus initiator for the 16x8 program/data RAM. It drives the RAM's address, write-data and write-enable (RI) lines and samples its read data.
- LOAD mode: takes bytes from an external valid/ready byte port and writes them sequentially into RAM addresses 0..15.
- DUMP mode: reads RAM 0..15 back out over a valid/ready output port.
- Sits between the board-level programming interface and the RAM. BUSY holds the CPU off the RAM bus while active.

---
 rtl/ram_loader_pkg.sv | 17 +
 rtl/ram_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ram_loader_pkg.sv
// Shared RAM bus geometry and loader state encoding, used by the loader,
// the RAM and the CPU bus mux.
package ram_loader_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_WR   = 3'd2,
        DP_RD   = 3'd3,
        DP_OUT  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// RAM bus initiator: loads DEPTH bytes from a valid/ready stream into RAM,
// or dumps RAM contents out over a valid/ready stream.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | bus released, waiting for START_LOAD / START_DUMP
//   LD_WAIT | IN_READY high, waiting for the next input byte
//   LD_WR   | RAM_RI high, byte written to RAM at the end of this cycle
//   DP_RD   | RAM addressed for read, data captured into OUT_DATA
//   DP_OUT  | OUT_VALID high, OUT_DATA held until the consumer takes it
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              START_LOAD,
    input  logic              START_DUMP,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DIN,
    output logic              RAM_RI,
    input  logic [DATA_W-1:0] RAM_DOUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state,    state_nxt;
    logic [ADDR_W-1:0] addr,     addr_nxt;
    logic [DATA_W-1:0] data_reg, data_nxt;
    logic [DATA_W-1:0] out_reg,  out_nxt;
    logic              done_reg, done_nxt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            addr     <= '0;
            data_reg <= '0;
            out_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            data_reg <= data_nxt;
            out_reg  <= out_nxt;
            done_reg <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        data_nxt  = data_reg;
        out_nxt   = out_reg;
        done_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (START_LOAD) begin
                    state_nxt = LD_WAIT;
                    addr_nxt  = '0;
                end else if (START_DUMP) begin
                    state_nxt = DP_RD;
                    addr_nxt  = '0;
                end
            end

            LD_WAIT: begin
                if (IN_VALID) begin
                    data_nxt  = IN_DATA;
                    state_nxt = LD_WR;
                end
            end

            LD_WR: begin
                if (addr == LAST_ADDR) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = LD_WAIT;
                end
            end

            DP_RD: begin
                out_nxt   = RAM_DOUT;
                state_nxt = DP_OUT;
            end

            DP_OUT: begin
                if (OUT_READY) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                        state_nxt = DP_RD;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a pure decode of registered state, so none has a
    // combinational path from an input.
    assign IN_READY  = (state == LD_WAIT);
    assign OUT_VALID = (state == DP_OUT);
    assign RAM_RI    = (state == LD_WR);
    assign BUSY      = (state != IDLE);
    assign DONE      = done_reg;
    assign RAM_ADDR  = addr;
    assign RAM_DIN   = data_reg;
    assign OUT_DATA  = out_reg;

endmodule
